// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and constants for the instruction cache
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_BYTOFF_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one cache way: valid bits, tags and block data with combinational lookup
module icache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS    = 8,
  parameter int WORDS   = 2,
  parameter int TAG_W   = 26,
  parameter int IDX_IW  = (SETS > 1) ? $clog2(SETS) : 1,
  parameter int WORD_IW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [IDX_IW-1:0]  rd_index,
  input  logic [WORD_IW-1:0] rd_word,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output word_t              rd_data,
  input  logic               wr_en,
  input  logic [IDX_IW-1:0]  wr_index,
  input  logic [WORD_IW-1:0] wr_word,
  input  word_t              wr_data,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               set_valid,
  input  logic               clr_line,
  input  logic               clr_all
);

  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tags [SETS];
  word_t            data [SETS][WORDS];

  // clr_all wins over a completing fill so an invalidate never leaves a live line
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (clr_all) begin
      valid <= '0;
    end else begin
      if (clr_line)  valid[wr_index] <= 1'b0;
      if (set_valid) valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (set_valid) tags[wr_index] <= wr_tag;
    if (wr_en)     data[wr_index][wr_word] <= wr_data;
  end

  assign hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_data = data[rd_index][rd_word];

endmodule

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - set-associative multi-word instruction cache with FIFO replacement
module icache_nway
  import cpu_types_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        halt,
  input  logic        inv,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int WORD_W  = $clog2(WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int PTR_W   = $clog2(WAYS);
  localparam int WORD_IW = (WORD_W > 0) ? WORD_W : 1;
  localparam int IDX_IW  = (IDX_W > 0) ? IDX_W : 1;
  localparam int PTR_IW  = (PTR_W > 0) ? PTR_W : 1;
  localparam int TAG_LSB = ICACHE_BYTOFF_W + WORD_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam logic [31:0] BLOCK_MASK = 32'(WORDS * 4 - 1);

  icache_state_t state, next_state;

  logic [WORD_IW-1:0] counter;
  logic [31:0]        miss_base;
  logic [PTR_IW-1:0]  victim;
  logic [PTR_IW-1:0]  vptr [SETS];

  logic               req_valid;
  logic [WORD_IW-1:0] req_word;
  logic [IDX_IW-1:0]  req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_IW-1:0]  miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic [IDX_IW-1:0]  wr_idx;

  logic [WAYS-1:0] way_hit;
  word_t           way_data [WAYS];
  logic            hit_any;
  word_t           hit_data;

  logic start_fill;
  logic fill_we;
  logic fill_done;
  logic last_word;

  assign req_valid = imemREN && !halt && !dmemREN && !dmemWEN;
  assign req_word  = WORD_IW'((imemaddr >> ICACHE_BYTOFF_W) % WORDS);
  assign req_idx   = IDX_IW'((imemaddr >> (ICACHE_BYTOFF_W + WORD_W)) % SETS);
  assign req_tag   = TAG_W'(imemaddr >> TAG_LSB);
  assign miss_idx  = IDX_IW'((miss_base >> (ICACHE_BYTOFF_W + WORD_W)) % SETS);
  assign miss_tag  = TAG_W'(miss_base >> TAG_LSB);
  assign last_word = (counter == WORD_IW'(WORDS - 1));
  // the victim's valid bit is cleared with the request index, fills use the latched one
  assign wr_idx    = (state == IDLE) ? req_idx : miss_idx;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS  (SETS),
      .WORDS (WORDS),
      .TAG_W (TAG_W)
    ) u_way (
      .CLK       (CLK),
      .nRST      (nRST),
      .rd_index  (req_idx),
      .rd_word   (req_word),
      .rd_tag    (req_tag),
      .hit       (way_hit[w]),
      .rd_data   (way_data[w]),
      .wr_en     (fill_we && (victim == PTR_IW'(w))),
      .wr_index  (wr_idx),
      .wr_word   (counter),
      .wr_data   (iload),
      .wr_tag    (miss_tag),
      .set_valid (fill_done && (victim == PTR_IW'(w))),
      .clr_line  (start_fill && (vptr[req_idx] == PTR_IW'(w))),
      .clr_all   (inv)
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any  = 1'b1;
        hit_data = way_data[w];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    start_fill = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !inv) begin
          if (hit_any) begin
            ihit     = 1'b1;
            imemload = hit_data;
          end else begin
            start_fill = 1'b1;
            next_state = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_base + (32'(counter) << ICACHE_BYTOFF_W);
        if (halt || inv) begin
          next_state = IDLE;
        end else if (!iwait) begin
          fill_we = 1'b1;
          if (last_word) begin
            fill_done  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      counter   <= '0;
      miss_base <= '0;
      victim    <= '0;
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else begin
      if (start_fill) begin
        counter   <= '0;
        miss_base <= imemaddr & ~BLOCK_MASK;
        victim    <= vptr[req_idx];
      end else if (fill_we && !last_word) begin
        counter <= counter + 1'b1;
      end
      if (inv) begin
        for (int s = 0; s < SETS; s++) vptr[s] <= '0;
      end else if (fill_done) begin
        vptr[miss_idx] <= (WAYS == 1) ? '0 : vptr[miss_idx] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - scoreboard bench for icache_nway with directed fetch sequences
module tb_icache_nway;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN, halt, inv, iwait;
  logic [31:0] imemaddr;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, iload;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  always #5 CLK = ~CLK;

  icache_nway dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .halt     (halt),
    .inv      (inv),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA0000 + (a >> 2) - 32'd15;
  endfunction

  assign iload = iREN ? mem_word(iaddr) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every hit and every accepted memory beat is matched against the queues
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (ihit) begin
          if (q_data.size() == 0) chk("unexpected_hit", imemload, 32'hFFFFFFFF);
          else chk("hit_data", imemload, q_data.pop_front());
          chk("hit_iren", {31'd0, iREN}, 32'd0);
        end else begin
          chk("miss_load_zero", imemload, 32'd0);
        end
        if (iREN && !iwait) begin
          if (q_addr.size() == 0) chk("unexpected_beat", iaddr, 32'hFFFFFFFF);
          else chk("beat_addr", iaddr, q_addr.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge CLK);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic fetch(input logic [31:0] a, input int exp_lat);
    int n = 0;
    @(posedge CLK); #1;
    imemaddr = a;
    imemREN  = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (!ihit && n < 50);
    chk("latency", 32'(n), 32'(exp_lat));
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  task automatic expect_fill(input logic [31:0] a, input logic [31:0] d);
    q_addr.push_back(a);
    q_addr.push_back(a + 32'd4);
    q_data.push_back(d);
    fetch(a, 4);
  endtask

  task automatic expect_hit(input logic [31:0] a, input logic [31:0] d);
    q_data.push_back(d);
    fetch(a, 1);
  endtask

  task automatic pulse_inv();
    @(posedge CLK); #1;
    inv = 1'b1;
    @(posedge CLK); #1;
    inv = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    halt = 1'b0; inv = 1'b0; iwait = 1'b0; imemaddr = '0;
    repeat (2) @(negedge CLK);
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // cold miss then same-block hit
    expect_fill(32'h40, 32'hAAAA0001);
    expect_hit(32'h44, 32'hAAAA0002);

    // FIFO replacement in set 0
    expect_fill(32'h240, 32'hAAAA0081);
    expect_fill(32'h440, 32'hAAAA0101);
    expect_hit(32'h240, 32'hAAAA0081);
    expect_fill(32'h40, 32'hAAAA0001);
    expect_hit(32'h440, 32'hAAAA0101);
    expect_fill(32'h240, 32'hAAAA0081);
    expect_hit(32'h40, 32'hAAAA0001);

    // invalidate with a hitting request present
    @(posedge CLK); #1;
    imemaddr = 32'h40; imemREN = 1'b1; inv = 1'b1;
    @(negedge CLK);
    chk("inv_ihit", {31'd0, ihit}, 32'd0);
    @(posedge CLK); #1;
    inv = 1'b0; imemREN = 1'b0;
    expect_fill(32'h40, 32'hAAAA0001);
    expect_hit(32'h44, 32'hAAAA0002);

    // wait stretching and address change during the fill
    pulse_inv();
    iwait = 1'b1; imemaddr = 32'h40; imemREN = 1'b1;
    q_addr.push_back(32'h40);
    q_addr.push_back(32'h44);
    @(negedge CLK);
    @(posedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("wait_iaddr", iaddr, 32'h40);
      chk("wait_iren", {31'd0, iREN}, 32'd1);
      chk("wait_ihit", {31'd0, ihit}, 32'd0);
      if (i == 2) imemaddr = 32'h80;
    end
    @(posedge CLK); #1;
    iwait = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    expect_hit(32'h40, 32'hAAAA0001);

    // halt after the first beat aborts the refill
    pulse_inv();
    imemaddr = 32'h40; imemREN = 1'b1;
    q_addr.push_back(32'h40);
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK); #1;
    halt = 1'b1; iwait = 1'b1;
    @(negedge CLK);
    chk("halt_iren_same", {31'd0, iREN}, 32'd1);
    @(negedge CLK);
    chk("halt_iren_next", {31'd0, iREN}, 32'd0);
    @(posedge CLK); #1;
    halt = 1'b0; iwait = 1'b0; imemREN = 1'b0;
    expect_fill(32'h40, 32'hAAAA0001);

    // data-port activity suppresses hits
    @(posedge CLK); #1;
    imemaddr = 32'h40; imemREN = 1'b1; dmemREN = 1'b1;
    @(negedge CLK);
    chk("dren_ihit", {31'd0, ihit}, 32'd0);
    chk("dren_iren", {31'd0, iREN}, 32'd0);
    chk("dren_load", imemload, 32'd0);
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b1;
    @(negedge CLK);
    chk("dwen_ihit", {31'd0, ihit}, 32'd0);
    @(posedge CLK); #1;
    dmemWEN = 1'b0;
    q_data.push_back(32'hAAAA0001);
    @(negedge CLK);
    chk("drop_ihit", {31'd0, ihit}, 32'd1);
    @(posedge CLK); #1;
    imemREN = 1'b0;

    repeat (3) @(posedge CLK);
    chk("addr_queue_empty", 32'(q_addr.size()), 32'd0);
    chk("data_queue_empty", 32'(q_data.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised, set-associative, multi-word-block instruction cache.
- Successor to the direct-mapped, one-word-per-line icache.
- Sits between the datapath instruction-fetch port and the memory arbiter's instruction channel.
- Adds configurable ways, sets and block size, FIFO replacement, a refill state machine with a latched miss address, and whole-cache invalidate.

Parameters:
- WAYS, 2, associativity (power of 2, at least 1).
- SETS, 8, sets per way (power of 2, at least 2).
- WORDS, 2, 32-bit words per block (power of 2, at least 1).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address.
- dmemREN  in  1  datapath data read active; suppresses ihit.
- dmemWEN  in  1  datapath data write active; suppresses ihit.
- halt  in  1  processor halted; suppresses ihit and aborts refill.
- inv  in  1  one-cycle pulse that invalidates all lines.
- ihit  out  1  fetch served this cycle.
- imemload  out  32  fetched instruction; 0 when ihit is 0.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; iload is valid when iwait=0 and iREN=1.
- iload  in  32  memory read data.

Behaviour:
- Address split, low to high:
  - byte offset: 2 bits
  - word offset: log2(WORDS) bits
  - index: log2(SETS) bits
  - tag: the remaining bits
- Per line: valid bit, tag, and WORDS data words. Per set: a victim pointer of log2(WAYS) bits.
- Reset (asynchronous):
  - all valid bits = 0, all victim pointers = 0, FSM = IDLE, word counter = 0, latched miss address = 0.
  - ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
  - Data and tag arrays need not be cleared.
- FSM states are IDLE and FILL.
- IDLE:
  - A request is valid when imemREN=1, halt=0, dmemREN=0 and dmemWEN=0.
  - On a valid request, all ways of the indexed set compare tags combinationally.
  - Hit (valid and tag equal in any way): ihit=1 and imemload = the addressed word in the same cycle. The state is not modified.
  - Miss: ihit=0. Latch imemaddr with the word offset cleared. The victim way is the set's pointer. Word counter = 0. Next state = FILL.
  - With no valid request, all outputs stay at 0.
- FILL:
  - iREN=1; iaddr = latched base + 4*counter.
  - On each cycle with iwait=0, write iload into victim line word[counter] and increment the counter.
  - When iwait=0 on word WORDS-1:
    - write the tag, set valid=1;
    - advance the set's victim pointer by 1, modulo WAYS;
    - next state = IDLE.
  - The retried fetch hits in the following cycle.
- Miss latency: 1 cycle to enter FILL, plus WORDS memory beats, plus 1 hit cycle.
- ihit stays 0 during FILL, even if the current imemaddr would hit.
- Changes on imemaddr during FILL do not affect the refill; it always completes for the latched address.
- dmemREN and dmemWEN do not stall FILL. Arbitration is visible only through iwait.
- halt=1 in FILL:
  - return to IDLE next cycle; iREN=0 from that cycle;
  - the victim line keeps valid=0 if it was cleared, or its old state otherwise;
  - the victim pointer does not advance.
- Line valid bit at refill start: the victim line's valid bit is cleared on the IDLE-to-FILL transition. An aborted fill therefore never exposes a mixed line.
- inv=1:
  - all valid bits are cleared at the clock edge; victim pointers reset to 0;
  - in FILL, the refill aborts as for halt;
  - inv takes priority over a completing fill in the same cycle, so that line ends invalid.
  - ihit is forced to 0 in the cycle inv is high.
- WAYS=1 degenerates to a direct-mapped cache: pointer width 0, victim always way 0.

Decomposition:
- cpu_types_pkg holds:
  - the icache_state_t enum {IDLE, FILL};
  - word_t;
  - the ICACHE_BYTOFF_W=2 constant.
- Parameter-dependent widths are derived localparams in the module.
- One sub-module, icache_way:
  - holds one way's valid, tag and data arrays;
  - provides a combinational tag compare and read word;
  - takes a write port (index, word, data, set-valid, clear-all).
- icache_nway instantiates WAYS copies and contains the FSM, the victim pointers and the hit mux.

Test Plan (default parameters: index = bits [5:3], word = bit [2], tag = bits [31:6]):
- Cold miss: imemREN=1 at 0x40.
  - Response: iREN=1 with iaddr 0x40, then 0x44 (iwait=0 each beat, iload 0xAAAA0001 / 0xAAAA0002).
  - Then ihit=1 and imemload=0xAAAA0001. A following fetch of 0x44 gives same-cycle ihit with 0xAAAA0002 and iREN=0.
- Associativity/FIFO: fill 0x040 (way 0), 0x240 (way 1), then 0x440.
  - 0x440 evicts way 0.
  - Fetch 0x240 hits; fetch 0x040 misses and refills into way 1.
- Wait stretching: iwait=1 for 5 cycles on beat 0.
  - iaddr is held at 0x40, ihit=0 throughout.
  - Change imemaddr to 0x80 mid-fill: the fill still completes for 0x40.
- Halt mid-fill: halt=1 after beat 0.
  - iREN=0 next cycle.
  - Deassert halt, fetch 0x40: it misses again and does a full 2-beat refill.
- Invalidate: with 0x40 cached, pulse inv.
  - ihit=0 that cycle.
  - The next fetch of 0x40 misses, and victim pointer 0 selects way 0.
- Data-port suppression: 0x40 cached, dmemREN=1.
  - ihit=0, iREN=0, imemload=0.
  - Drop dmemREN: ihit=1 in the same cycle.
